emif_calbus_arbiter: RTL and testbench
======================================

# emif_calbus_arbiter

Shares the single EMIF calibration component bus (20-bit address, 32-bit data, one-cycle read/write strobes) between N on-chip requesters, e.g. the debug bridge and the boot-time calibration/config sequencer. The block round-robin arbitrates valid/ready requests and issues exactly one bus transaction at a time. For reads it waits a fixed bus read latency and captures read data. It returns a response to the granted requester. It sits between the requesters and the `emif_cal` calbus pins, in the `calbus_clk` domain.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, ≥1.
- `RD_LATENCY`, default 2: cycles from the `calbus_read_o` strobe to valid `calbus_rdata_i`, ≥1.

Ports:
- `clk_i` in 1: calbus clock; all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in NUM_REQ: per-requester request valid.
- `req_ready_o` out NUM_REQ: per-requester accept; one-hot or zero.
- `req_write_i` in NUM_REQ: 1 = write, 0 = read.
- `req_addr_i` in NUM_REQ*20: packed addresses; requester i at [i*20 +: 20].
- `req_wdata_i` in NUM_REQ*32: packed write data.
- `rsp_valid_o` out NUM_REQ: response valid to the owner; one-hot or zero.
- `rsp_ready_i` in NUM_REQ: response accept.
- `rsp_rdata_o` out 32: read data, shared; meaningful only with `rsp_valid_o` and only for reads.
- `calbus_read_o` out 1: read strobe.
- `calbus_write_o` out 1: write strobe.
- `calbus_address_o` out 20: bus address.
- `calbus_wdata_o` out 32: bus write data.
- `calbus_rdata_i` in 32: bus read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Round-robin grant among asserted `req_valid_i`, starting at priority pointer `ptr`.
  - `req_ready_o[g]` is 1 for the winner only; it is combinational from valid and `ptr`.
  - On handshake: latch owner `g`, write flag, address and wdata; set `ptr` = (g+1) mod NUM_REQ; go to ISSUE.
  - With no valid request, stay in IDLE and leave `ptr` unchanged.
- **ISSUE** (exactly one cycle)
  - Drive `calbus_read_o` or `calbus_write_o` = 1 with the latched address and wdata.
  - Read: load counter = RD_LATENCY−1 and go to WAIT.
  - Write: go to RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reads 0, capture `calbus_rdata_i` into `rsp_rdata_o` and go to RESP.
- **RESP**
  - `rsp_valid_o[owner]` = 1, held with stable data until `rsp_ready_i[owner]`.
  - On handshake, go to IDLE.
  - `rsp_ready_i` of non-owners is ignored.
- `calbus_address_o` and `calbus_wdata_o` hold the last latched values outside ISSUE. Strobes are 0 outside ISSUE.
- No request is accepted outside IDLE. Requesters must hold request fields stable while valid and not ready.
- A requester dropping valid before ready is legal; nothing is issued for it.
- **Reset** (any state, including mid-transaction)
  - Next state is IDLE and `ptr` = 0; any pending transaction is dropped with no response.
  - All outputs are 0: strobes, `req_ready_o`, `rsp_valid_o`, `calbus_address_o`, `calbus_wdata_o`, `rsp_rdata_o`.
  - `req_ready_o` is forced to 0 while `rst_i` = 1.

## Timing
- Request handshake at cycle T → strobe at T+1.
- Read: data sampled at edge ending T+1+RD_LATENCY; `rsp_valid_o` first high at T+2+RD_LATENCY.
- Write: `rsp_valid_o` first high at T+2.
- Response handshake at cycle R → earliest next request handshake at R+1.
- Back-to-back throughput:
  - Writes: one per 3 cycles.
  - Reads: one per RD_LATENCY+3 cycles.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.

## Structure
- Package `emif_cal_pkg`:
  - `CALBUS_ADDR_W`=20, `CALBUS_DATA_W`=32.
  - FSM enum `calbus_arb_state_e` {IDLE, ISSUE, WAIT, RESP}.
- Sub-module `emif_calbus_rr_arb`:
  - Combinational round-robin grant; inputs: request vector, `ptr`; outputs: one-hot grant, index.
  - `ptr` register stays in the top.
- Counter width `$clog2(RD_LATENCY+1)`.

## Test plan
- **Single read:** requester 0 reads 0x00123, RD_LATENCY=2, bus returns 0xDEADBEEF at the sampling edge.
  - `calbus_read_o` is high for 1 cycle at T+1 with address 0x00123.
  - `rsp_valid_o`=01 at T+4 with `rsp_rdata_o`=0xDEADBEEF.
- **Write:** requester 1 writes 0x5A5A5A5A to 0xFFFFF.
  - `calbus_write_o` is high at T+1 with matching address and data.
  - `rsp_valid_o`=10 at T+2.
- **Contention:** both requesters valid continuously after reset.
  - Grants alternate 0,1,0,1.
  - No strobe ever overlaps a response wait.
- **Response backpressure:** `rsp_ready_i` held low for 5 cycles.
  - `rsp_valid_o` and `rsp_rdata_o` stay stable.
  - `req_ready_o` stays 0; no new strobe is issued.
- **Reset mid-WAIT:** assert `rst_i` during a read's WAIT.
  - All outputs are 0 the next cycle; no response is ever issued for that read.
  - The first grant after reset goes to requester 0.

Source files
------------

// File: rtl/emif_cal_pkg.sv
// Shared definitions for the EMIF calibration-bus arbiter.
//   CALBUS_ADDR_W / CALBUS_DATA_W : calbus address and data widths
//   calbus_arb_state_e            : arbiter FSM states
package emif_cal_pkg;

  localparam int CALBUS_ADDR_W = 20;
  localparam int CALBUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } calbus_arb_state_e;

endpackage

// File: rtl/emif_calbus_rr_arb.sv
// Combinational round-robin grant.
//   req : request vector
//   ptr : index with highest priority this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted requester (0 when no request)
module emif_calbus_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  // Scan requesters starting at ptr, wrapping once; first hit wins.
  always_comb begin
    int  j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/emif_calbus_arbiter.sv
// Arbitrates N requesters onto the single EMIF calibration component bus.
// One transaction in flight at a time: grant -> strobe -> (read wait) -> response.
//   clk_i, rst_i          : calbus clock, synchronous active-high reset
//   req_*                 : per-requester valid/ready request channel (packed fields)
//   rsp_*                 : per-requester valid/ready response channel, shared rdata
//   calbus_*              : calbus master pins (one-cycle read/write strobes)
module emif_calbus_arbiter
  import emif_cal_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0]                 req_write_i,
  input  logic [NUM_REQ*CALBUS_ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*CALBUS_DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  input  logic [NUM_REQ-1:0]                 rsp_ready_i,
  output logic [CALBUS_DATA_W-1:0]           rsp_rdata_o,
  output logic                               calbus_read_o,
  output logic                               calbus_write_o,
  output logic [CALBUS_ADDR_W-1:0]           calbus_address_o,
  output logic [CALBUS_DATA_W-1:0]           calbus_wdata_o,
  input  logic [CALBUS_DATA_W-1:0]           calbus_rdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  calbus_arb_state_e          state_reg, state_next;
  logic [IDX_W-1:0]           ptr_reg;
  logic [IDX_W-1:0]           owner_reg;
  logic                       write_reg;
  logic [CALBUS_ADDR_W-1:0]   addr_reg;
  logic [CALBUS_DATA_W-1:0]   wdata_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic [CALBUS_DATA_W-1:0]   rdata_reg;

  logic [NUM_REQ-1:0]         gnt;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       req_hs;
  logic                       rsp_hs;

  emif_calbus_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req (req_valid_i),
    .ptr (ptr_reg),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Ready is offered only in IDLE and never while reset is asserted.
  assign req_ready_o = (!rst_i && state_reg == IDLE) ? gnt : '0;
  assign req_hs      = |(req_valid_i & req_ready_o);
  // Non-owner rsp_ready bits are simply never looked at.
  assign rsp_hs      = (state_reg == RESP) && rsp_ready_i[owner_reg];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_hs) state_next = ISSUE;
      ISSUE:   state_next = write_reg ? RESP : WAIT;
      WAIT:    if (cnt_reg == '0) state_next = RESP;
      RESP:    if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_hs) begin
        owner_reg <= gnt_idx;
        write_reg <= req_write_i[gnt_idx];
        addr_reg  <= req_addr_i[gnt_idx*CALBUS_ADDR_W +: CALBUS_ADDR_W];
        wdata_reg <= req_wdata_i[gnt_idx*CALBUS_DATA_W +: CALBUS_DATA_W];
        ptr_reg   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // Counter counts remaining WAIT cycles; the cycle it reads 0 is the
      // one in which read data is valid on the bus.
      if (state_reg == ISSUE) begin
        cnt_reg <= CNT_W'(RD_LATENCY - 1);
      end
      if (state_reg == WAIT) begin
        if (cnt_reg == '0) rdata_reg <= calbus_rdata_i;
        else               cnt_reg   <= cnt_reg - 1'b1;
      end
    end
  end

  assign calbus_read_o    = (state_reg == ISSUE) && !write_reg;
  assign calbus_write_o   = (state_reg == ISSUE) &&  write_reg;
  assign calbus_address_o = addr_reg;
  assign calbus_wdata_o   = wdata_reg;
  assign rsp_rdata_o      = rdata_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
      assign rsp_valid_o[gi] = (state_reg == RESP) && (owner_reg == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_emif_calbus_arbiter.sv
// Self-checking bench for emif_calbus_arbiter (NUM_REQ=2, RD_LATENCY=2).
// A transaction-level reference model predicts grant, strobe cycle, response
// cycle and read data from the arbitration/timing rules; every cycle the DUT
// outputs are compared against it. Directed scenarios are followed by a
// randomized phase.
module tb_emif_calbus_arbiter;

  localparam int N = 2;
  localparam int L = 2;

  logic             clk;
  logic             rst_i;
  logic [N-1:0]     req_valid_i, req_ready_o, req_write_i;
  logic [N*20-1:0]  req_addr_i;
  logic [N*32-1:0]  req_wdata_i;
  logic [N-1:0]     rsp_valid_o, rsp_ready_i;
  logic [31:0]      rsp_rdata_o;
  logic             calbus_read_o, calbus_write_o;
  logic [19:0]      calbus_address_o;
  logic [31:0]      calbus_wdata_o, calbus_rdata_i;

  emif_calbus_arbiter #(.NUM_REQ(N), .RD_LATENCY(L)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_write_i      (req_write_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_rdata_o      (rsp_rdata_o),
    .calbus_read_o    (calbus_read_o),
    .calbus_write_o   (calbus_write_o),
    .calbus_address_o (calbus_address_o),
    .calbus_wdata_o   (calbus_wdata_o),
    .calbus_rdata_i   (calbus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus slave: data for a read strobe appears exactly L cycles later; other
  // cycles carry random noise so a mistimed capture is caught.
  function automatic logic [31:0] bus_data(input logic [19:0] a);
    if (a == 20'h00123) return 32'hDEADBEEF;
    return {a[11:0], a} ^ 32'h1357_9BDF;
  endfunction

  logic [L-1:0] pipe_v = '0;
  logic [19:0]  pipe_a [L];
  logic [31:0]  noise  = 32'h0;

  always @(posedge clk) begin
    pipe_v[0] <= calbus_read_o;
    pipe_a[0] <= calbus_address_o;
    for (int k = 1; k < L; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_a[k] <= pipe_a[k-1];
    end
    noise <= $urandom;
  end

  assign calbus_rdata_i = pipe_v[L-1] ? bus_data(pipe_a[L-1]) : noise;

  // Requester-side stimulus state.
  logic         p_valid [N];
  logic         p_write [N];
  logic [19:0]  p_addr  [N];
  logic [31:0]  p_wdata [N];
  logic [N-1:0] b_rsp_rdy;
  logic         b_rst;

  // Reference model.
  int           cyc;
  logic         m_busy;
  int           m_owner, m_ptr, m_strobe, m_rsp;
  logic         m_write;
  logic [19:0]  m_addr;
  logic [31:0]  m_wdata, m_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int grant_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_ptr   = 0;
    m_owner = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_rsp;
    int g;
    rst_i       = b_rst;
    rsp_ready_i = b_rsp_rdy;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]           = p_valid[i];
      req_write_i[i]           = p_write[i];
      req_addr_i[i*20 +: 20]   = p_addr[i];
      req_wdata_i[i*32 +: 32]  = p_wdata[i];
      v[i]                     = p_valid[i];
    end
    #1;
    g = (m_busy || b_rst) ? -1 : rr_winner(v, m_ptr);
    chk("req_ready", 32'(req_ready_o), (g >= 0) ? 32'(1 << g) : 32'h0);
    if (!b_rst) begin
      exp_rsp = (m_busy && cyc >= m_rsp) ? N'(1 << m_owner) : '0;
      chk("read_strobe",  32'(calbus_read_o),  32'(m_busy && cyc == m_strobe && !m_write));
      chk("write_strobe", 32'(calbus_write_o), 32'(m_busy && cyc == m_strobe &&  m_write));
      chk("address",      32'(calbus_address_o), 32'(m_addr));
      chk("wdata",        calbus_wdata_o, m_wdata);
      chk("rsp_valid",    32'(rsp_valid_o), 32'(exp_rsp));
      chk("rsp_rdata",    rsp_rdata_o, m_rdata);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready_o[i] && req_valid_i[i]) begin
        grant_q.push_back(i);
        $display("txn cyc=%0d req%0d %s addr=%05h wdata=%08h", cyc, i,
                 p_write[i] ? "WR" : "RD", p_addr[i], p_wdata[i]);
      end
    end
    @(posedge clk);
    if (b_rst) begin
      model_reset();
    end else if (!m_busy && g >= 0) begin
      m_busy     = 1'b1;
      m_owner    = g;
      m_write    = p_write[g];
      m_addr     = p_addr[g];
      m_wdata    = p_wdata[g];
      m_strobe   = cyc + 1;
      m_rsp      = cyc + 2 + (p_write[g] ? 0 : L);
      m_ptr      = (g + 1) % N;
      p_valid[g] = 1'b0;
    end else if (m_busy) begin
      if (!m_write && cyc == m_rsp - 1) m_rdata = bus_data(m_addr);
      if (cyc >= m_rsp && b_rsp_rdy[m_owner]) m_busy = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue(input int i, input logic w, input logic [19:0] a, input logic [31:0] d);
    p_valid[i] = 1'b1;
    p_write[i] = w;
    p_addr[i]  = a;
    p_wdata[i] = d;
  endtask

  task automatic do_reset();
    b_rst = 1'b1;
    run(2);
    b_rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    m_write = 1'b0; m_strobe = 0; m_rsp = 0;
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    b_rsp_rdy = '1;
    b_rst     = 1'b1;
    rst_i = 1'b1; req_valid_i = '0; req_write_i = '0; req_addr_i = '0;
    req_wdata_i = '0; rsp_ready_i = '0;
    @(negedge clk);

    // Reset state, then an idle cycle with every output checked.
    do_reset();
    run(2);

    // Single read of 0x00123 by requester 0 (bus returns 0xDEADBEEF).
    issue(0, 1'b0, 20'h00123, 32'h0);
    run(7);

    // Write of 0x5A5A5A5A to 0xFFFFF by requester 1.
    issue(1, 1'b1, 20'hFFFFF, 32'h5A5A5A5A);
    run(5);

    // Contention: both requesters continuously valid right after reset.
    do_reset();
    grant_q.delete();
    for (int k = 0; k < 40 && grant_q.size() < 4; k++) begin
      for (int i = 0; i < N; i++)
        if (!p_valid[i]) issue(i, 1'b1, 20'($urandom), $urandom);
      step();
    end
    chk("contention_grants", 32'(grant_q.size() >= 4), 32'h1);
    for (int k = 0; k < 4; k++)
      if (grant_q.size() > k) chk("contention_order", 32'(grant_q[k]), 32'(k % 2));
    run(8);

    // Response backpressure with the other requester waiting.
    b_rsp_rdy = '0;
    issue(0, 1'b0, 20'h0ABCD, 32'h0);
    run(1);
    issue(1, 1'b1, 20'h00010, 32'hCAFEF00D);
    run(10);
    b_rsp_rdy = '1;
    run(8);

    // Reset during a read's WAIT; first grant afterwards must go to 0.
    issue(0, 1'b0, 20'h00777, 32'h0);
    run(3);
    issue(1, 1'b1, 20'h00042, 32'h11111111);
    b_rst = 1'b1;
    run(1);
    b_rst = 1'b0;
    issue(0, 1'b1, 20'h00043, 32'h22222222);
    grant_q.delete();
    run(6);
    chk("post_reset_first_grant", (grant_q.size() > 0) ? 32'(grant_q[0]) : 32'hFFFF_FFFF, 32'h0);
    run(6);

    // Randomized traffic with random response backpressure and drops.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 5))
            0:       issue(i, 1'($urandom), 20'h00123, $urandom);
            1:       issue(i, 1'($urandom), 20'hFFFFF, $urandom);
            default: issue(i, 1'($urandom), 20'($urandom), $urandom);
          endcase
        end else if (p_valid[i] && $urandom_range(0, 19) == 0) begin
          p_valid[i] = 1'b0;
        end
      end
      b_rsp_rdy = N'($urandom);
      b_rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    b_rst = 1'b0;
    b_rsp_rdy = '1;
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
